// File: rtl/rc5_session_ctrl_if.sv
// rtl/rc5_session_ctrl_if.sv - host/key/expander/engine/result signal bundle for rc5_session_ctrl
interface rc5_session_ctrl_if #(
  parameter int W        = 32,
  parameter int B        = 16,
  parameter int B_LENGTH = $clog2(B),
  parameter int CNT_W    = 16
);
  logic                iKeyValid;
  logic [7:0]          iKeyByte;
  logic                oKeyReady;
  logic                oKey_we;
  logic [B_LENGTH-1:0] oKey_addr;
  logic [7:0]          oKey_data;
  logic                oExpStart;
  logic                iExpDone;
  logic                oS_sel;
  logic                iRekey;
  logic                iInValid;
  logic                oInReady;
  logic [W-1:0]        iA;
  logic [W-1:0]        iB;
  logic                iDecrypt;
  logic                oEngStart;
  logic [W-1:0]        oEngA;
  logic [W-1:0]        oEngB;
  logic                oEngDecrypt;
  logic                iEngDone;
  logic [W-1:0]        iEngA;
  logic [W-1:0]        iEngB;
  logic                oOutValid;
  logic                iOutReady;
  logic [W-1:0]        oA;
  logic [W-1:0]        oB;
  logic [CNT_W-1:0]    oBlockCount;
  logic                oKeyLoaded;

  modport master (
    output iKeyValid, iKeyByte, iExpDone, iRekey, iInValid, iA, iB, iDecrypt,
           iEngDone, iEngA, iEngB, iOutReady,
    input  oKeyReady, oKey_we, oKey_addr, oKey_data, oExpStart, oS_sel, oInReady,
           oEngStart, oEngA, oEngB, oEngDecrypt, oOutValid, oA, oB, oBlockCount, oKeyLoaded
  );

  modport slave (
    input  iKeyValid, iKeyByte, iExpDone, iRekey, iInValid, iA, iB, iDecrypt,
           iEngDone, iEngA, iEngB, iOutReady,
    output oKeyReady, oKey_we, oKey_addr, oKey_data, oExpStart, oS_sel, oInReady,
           oEngStart, oEngA, oEngB, oEngDecrypt, oOutValid, oA, oB, oBlockCount, oKeyLoaded
  );
endinterface

// File: rtl/rc5_session_ctrl.sv
// rtl/rc5_session_ctrl.sv - RC5 session sequencer: key load, expansion, block service
module rc5_session_ctrl #(
  parameter int W        = 32,
  parameter int B        = 16,
  parameter int B_LENGTH = $clog2(B),
  parameter int CNT_W    = 16
) (
  input logic               clk,
  input logic               rst,
  rc5_session_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    KEY_LOAD, EXP_START, EXP_WAIT, SETTLE, IDLE, RUN, OUT
  } state_t;

  state_t              state, state_nxt;
  logic [B_LENGTH-1:0] key_cnt;
  logic                settle_cnt;
  logic                key_fire, in_fire, rekey_take, settle_done, exp_done, eng_done, out_fire;

  always_ff @(posedge clk) begin
    if (!rst) state <= KEY_LOAD;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    key_fire      = 1'b0;
    in_fire       = 1'b0;
    rekey_take    = 1'b0;
    settle_done   = 1'b0;
    exp_done      = 1'b0;
    eng_done      = 1'b0;
    out_fire      = 1'b0;
    bus.oKeyReady = 1'b0;
    bus.oKey_we   = 1'b0;
    bus.oKey_addr = key_cnt;
    bus.oKey_data = 8'h00;
    bus.oExpStart = 1'b0;
    bus.oInReady  = 1'b0;
    case (state)
      KEY_LOAD: begin
        bus.oKeyReady = 1'b1;
        bus.oKey_we   = bus.iKeyValid;
        bus.oKey_data = bus.iKeyByte;
        key_fire      = bus.iKeyValid;
        if (key_fire && key_cnt == B_LENGTH'(B - 1)) state_nxt = EXP_START;
      end
      EXP_START: begin
        bus.oExpStart = 1'b1;
        state_nxt     = EXP_WAIT;
      end
      EXP_WAIT: begin
        // Only levels seen after the start pulse count; a stale done is never sampled here.
        exp_done = bus.iExpDone;
        if (exp_done) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt) begin
          settle_done = 1'b1;
          state_nxt   = IDLE;
        end
      end
      IDLE: begin
        bus.oInReady = 1'b1;
        if (bus.iRekey) begin
          rekey_take = 1'b1;
          state_nxt  = KEY_LOAD;
        end else if (bus.iInValid) begin
          in_fire   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        eng_done = bus.iEngDone;
        if (eng_done) state_nxt = OUT;
      end
      OUT: begin
        out_fire = bus.iOutReady;
        if (out_fire) state_nxt = IDLE;
      end
      default: state_nxt = KEY_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      key_cnt         <= '0;
      settle_cnt      <= 1'b0;
      bus.oS_sel      <= 1'b0;
      bus.oKeyLoaded  <= 1'b0;
      bus.oEngStart   <= 1'b0;
      bus.oEngA       <= W'(0);
      bus.oEngB       <= W'(0);
      bus.oEngDecrypt <= 1'b0;
      bus.oOutValid   <= 1'b0;
      bus.oA          <= W'(0);
      bus.oB          <= W'(0);
      bus.oBlockCount <= CNT_W'(0);
    end else begin
      bus.oEngStart <= in_fire;
      if (key_fire)
        key_cnt <= (key_cnt == B_LENGTH'(B - 1)) ? '0 : key_cnt + 1'b1;
      // S-RAM port A moves to the engine as soon as the expander reports done.
      if (exp_done) begin
        bus.oS_sel <= 1'b1;
        settle_cnt <= 1'b0;
      end
      if (state == SETTLE) settle_cnt <= 1'b1;
      if (settle_done) begin
        bus.oKeyLoaded  <= 1'b1;
        bus.oBlockCount <= CNT_W'(0);
      end
      if (rekey_take) begin
        bus.oKeyLoaded <= 1'b0;
        bus.oS_sel     <= 1'b0;
      end
      if (in_fire) begin
        bus.oEngA       <= bus.iA;
        bus.oEngB       <= bus.iB;
        bus.oEngDecrypt <= bus.iDecrypt;
      end
      if (eng_done) begin
        bus.oA        <= bus.iEngA;
        bus.oB        <= bus.iEngB;
        bus.oOutValid <= 1'b1;
      end
      if (out_fire) begin
        bus.oOutValid   <= 1'b0;
        bus.oBlockCount <= bus.oBlockCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rc5_session_ctrl.sv
// tb/tb_rc5_session_ctrl.sv - scoreboard bench for rc5_session_ctrl
module tb_rc5_session_ctrl;
  localparam int W = 32, B = 16, BL = 4, CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [2*W-1:0] exp_q[$];

  rc5_session_ctrl_if #(.W(W), .B(B), .B_LENGTH(BL), .CNT_W(CW)) ifc ();

  rc5_session_ctrl #(.W(W), .B(B), .B_LENGTH(BL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(ifc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic [2*W-1:0] eng_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic dec);
    return dec ? {b ^ 32'hB7E15163, a - 32'h9E3779B9} : {a + 32'h9E3779B9, b ^ 32'hB7E15163};
  endfunction

  task automatic clear_inputs;
    ifc.iKeyValid = 0; ifc.iKeyByte = 0; ifc.iExpDone = 0; ifc.iRekey = 0;
    ifc.iInValid = 0; ifc.iA = 0; ifc.iB = 0; ifc.iDecrypt = 0;
    ifc.iEngDone = 0; ifc.iEngA = 0; ifc.iEngB = 0; ifc.iOutReady = 0;
  endtask

  task automatic load_key(input logic [7:0] base);
    rst = 1'b1;
    for (int i = 0; i < B; i++) begin
      ifc.iKeyValid = 1'b1;
      ifc.iKeyByte  = base + 8'(i);
      #1;
      checks++;
      if (ifc.oKey_we !== 1'b1 || ifc.oKey_addr !== 4'(i) || ifc.oKey_data !== base + 8'(i))
        begin failures++; $display("FAIL key_write[%0d]: we=%b addr=%0d data=%h want 1/%0d/%h",
                                   i, ifc.oKey_we, ifc.oKey_addr, ifc.oKey_data, i, base + 8'(i)); end
      tick;
    end
    ifc.iKeyValid = 1'b0;
    #1;
    checks++;
    if (ifc.oExpStart !== 1'b1 || ifc.oKeyReady !== 1'b0)
      begin failures++; $display("FAIL exp_start_pulse: start=%b keyready=%b want 1/0",
                                 ifc.oExpStart, ifc.oKeyReady); end
    tick;
    checks++;
    if (ifc.oExpStart !== 1'b0)
      begin failures++; $display("FAIL exp_start_single: start=%b want 0", ifc.oExpStart); end
  endtask

  task automatic expand(input int lat);
    ifc.iKeyValid = 1'b1;
    #1;
    checks++;
    if (ifc.oKey_we !== 1'b0)
      begin failures++; $display("FAIL key_ignored: we=%b want 0", ifc.oKey_we); end
    ifc.iKeyValid = 1'b0;
    repeat (lat) tick;
    checks++;
    if (ifc.oS_sel !== 1'b0 || ifc.oInReady !== 1'b0)
      begin failures++; $display("FAIL exp_wait: sel=%b inready=%b want 0/0", ifc.oS_sel, ifc.oInReady); end
    ifc.iExpDone = 1'b1;
    tick;
    ifc.iExpDone = 1'b0;
    #1;
    checks++;
    if (ifc.oS_sel !== 1'b1 || ifc.oInReady !== 1'b0 || ifc.oKeyLoaded !== 1'b0)
      begin failures++; $display("FAIL settle1: sel=%b inready=%b loaded=%b want 1/0/0",
                                 ifc.oS_sel, ifc.oInReady, ifc.oKeyLoaded); end
    tick;
    checks++;
    if (ifc.oS_sel !== 1'b1 || ifc.oInReady !== 1'b0)
      begin failures++; $display("FAIL settle2: sel=%b inready=%b want 1/0", ifc.oS_sel, ifc.oInReady); end
    tick;
    checks++;
    if (ifc.oInReady !== 1'b1 || ifc.oKeyLoaded !== 1'b1 || ifc.oBlockCount !== 2'd0)
      begin failures++; $display("FAIL idle_entry: inready=%b loaded=%b count=%0d want 1/1/0",
                                 ifc.oInReady, ifc.oKeyLoaded, ifc.oBlockCount); end
  endtask

  task automatic run_block(input logic [W-1:0] a, input logic [W-1:0] b, input logic dec,
                           input int lat, input int hold, input logic [CW-1:0] exp_cnt);
    logic [2*W-1:0] r, e;
    logic           stable;
    int             n;
    ifc.iInValid = 1'b1; ifc.iA = a; ifc.iB = b; ifc.iDecrypt = dec;
    #1;
    n = 0;
    while (ifc.oInReady !== 1'b1 && n < 20) begin tick; #1; n++; end
    checks++;
    if (ifc.oInReady !== 1'b1)
      begin failures++; $display("FAIL in_ready_timeout: inready=%b want 1", ifc.oInReady); end
    exp_q.push_back(eng_model(a, b, dec));
    tick;
    ifc.iInValid = 1'b0; ifc.iA = $urandom; ifc.iB = $urandom; ifc.iDecrypt = ~dec;
    #1;
    checks++;
    if (ifc.oEngStart !== 1'b1 || ifc.oEngA !== a || ifc.oEngB !== b || ifc.oEngDecrypt !== dec ||
        ifc.oInReady !== 1'b0)
      begin failures++; $display("FAIL eng_start: start=%b A=%h B=%h dec=%b inready=%b want 1/%h/%h/%b/0",
                                 ifc.oEngStart, ifc.oEngA, ifc.oEngB, ifc.oEngDecrypt, ifc.oInReady,
                                 a, b, dec); end
    tick;
    checks++;
    if (ifc.oEngStart !== 1'b0)
      begin failures++; $display("FAIL eng_start_single: start=%b want 0", ifc.oEngStart); end
    repeat (lat) tick;
    r = eng_model(a, b, dec);
    ifc.iEngDone = 1'b1; ifc.iEngA = r[2*W-1:W]; ifc.iEngB = r[W-1:0];
    tick;
    ifc.iEngDone = 1'b0; ifc.iEngA = $urandom; ifc.iEngB = $urandom;
    #1;
    e = exp_q.pop_front();
    checks++;
    if (ifc.oOutValid !== 1'b1 || {ifc.oA, ifc.oB} !== e)
      begin failures++; $display("FAIL result: valid=%b AB=%h want 1/%h", ifc.oOutValid,
                                 {ifc.oA, ifc.oB}, e); end
    stable = 1'b1;
    for (int j = 0; j < hold; j++) begin
      tick;
      if (ifc.oOutValid !== 1'b1 || {ifc.oA, ifc.oB} !== e || ifc.oInReady !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) begin
      checks++;
      if (stable !== 1'b1)
        begin failures++; $display("FAIL backpressure_hold: stable=%b want 1", stable); end
    end
    ifc.iOutReady = 1'b1;
    tick;
    ifc.iOutReady = 1'b0;
    #1;
    checks++;
    if (ifc.oOutValid !== 1'b0 || ifc.oInReady !== 1'b1 || ifc.oBlockCount !== exp_cnt)
      begin failures++; $display("FAIL out_done: valid=%b inready=%b count=%0d want 0/1/%0d",
                                 ifc.oOutValid, ifc.oInReady, ifc.oBlockCount, exp_cnt); end
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b0;
    repeat (3) tick;
    checks++;
    if (ifc.oKeyReady !== 1'b1 || ifc.oKey_addr !== 4'd0 ||
        {ifc.oKey_we, ifc.oExpStart, ifc.oS_sel, ifc.oInReady, ifc.oEngStart, ifc.oEngDecrypt,
         ifc.oOutValid, ifc.oKeyLoaded} !== 8'h00)
      begin failures++; $display("FAIL reset_ctrl: keyready=%b addr=%0d flags=%b want 1/0/00000000",
                                 ifc.oKeyReady, ifc.oKey_addr,
                                 {ifc.oKey_we, ifc.oExpStart, ifc.oS_sel, ifc.oInReady,
                                  ifc.oEngStart, ifc.oEngDecrypt, ifc.oOutValid, ifc.oKeyLoaded}); end
    checks++;
    if ({ifc.oEngA, ifc.oEngB, ifc.oA, ifc.oB} !== 128'd0 || ifc.oBlockCount !== 2'd0)
      begin failures++; $display("FAIL reset_data: engA=%h A=%h count=%0d want 0",
                                 ifc.oEngA, ifc.oA, ifc.oBlockCount); end
  endtask

  task automatic test_key_and_block;
    load_key(8'h00);
    expand(100);
    run_block(32'h0, 32'h0, 1'b0, 5, 0, 2'd1);
  endtask

  task automatic test_backpressure;
    run_block(32'h01234567, 32'h89ABCDEF, 1'b1, 3, 10, 2'd2);
  endtask

  task automatic test_rekey;
    ifc.iRekey = 1'b1; ifc.iInValid = 1'b1; ifc.iA = 32'hDEADBEEF;
    tick;
    ifc.iRekey = 1'b0; ifc.iInValid = 1'b0;
    #1;
    checks++;
    if (ifc.oKeyReady !== 1'b1 || ifc.oKeyLoaded !== 1'b0 || ifc.oS_sel !== 1'b0 ||
        ifc.oEngStart !== 1'b0 || ifc.oInReady !== 1'b0)
      begin failures++; $display("FAIL rekey_collision: keyready=%b loaded=%b sel=%b start=%b inready=%b want 1/0/0/0/0",
                                 ifc.oKeyReady, ifc.oKeyLoaded, ifc.oS_sel, ifc.oEngStart, ifc.oInReady); end
    load_key(8'h40);
    expand(20);
  endtask

  task automatic test_reset_mid;
    ifc.iRekey = 1'b1;
    tick;
    ifc.iRekey = 1'b0;
    load_key(8'h80);
    rst = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    checks++;
    if (ifc.oKeyReady !== 1'b1 || ifc.oS_sel !== 1'b0 || ifc.oExpStart !== 1'b0 || ifc.oKeyLoaded !== 1'b0)
      begin failures++; $display("FAIL reset_exp_wait: keyready=%b sel=%b start=%b loaded=%b want 1/0/0/0",
                                 ifc.oKeyReady, ifc.oS_sel, ifc.oExpStart, ifc.oKeyLoaded); end
    ifc.iExpDone = 1'b1;
    tick;
    ifc.iExpDone = 1'b0;
    #1;
    checks++;
    if (ifc.oKeyReady !== 1'b1 || ifc.oS_sel !== 1'b0)
      begin failures++; $display("FAIL late_exp_done: keyready=%b sel=%b want 1/0", ifc.oKeyReady, ifc.oS_sel); end
    load_key(8'hC0);
    expand(7);
    ifc.iInValid = 1'b1; ifc.iA = 32'h11111111; ifc.iB = 32'h22222222;
    tick;
    ifc.iInValid = 1'b0;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    checks++;
    if (ifc.oKeyReady !== 1'b1 || ifc.oEngStart !== 1'b0 || ifc.oEngA !== 32'd0 ||
        ifc.oKeyLoaded !== 1'b0 || ifc.oInReady !== 1'b0 || ifc.oS_sel !== 1'b0)
      begin failures++; $display("FAIL reset_run: keyready=%b start=%b engA=%h loaded=%b inready=%b sel=%b want 1/0/0/0/0/0",
                                 ifc.oKeyReady, ifc.oEngStart, ifc.oEngA, ifc.oKeyLoaded,
                                 ifc.oInReady, ifc.oS_sel); end
    ifc.iEngDone = 1'b1; ifc.iEngA = 32'hFFFFFFFF;
    tick;
    ifc.iEngDone = 1'b0;
    #1;
    checks++;
    if (ifc.oOutValid !== 1'b0 || ifc.oA !== 32'd0)
      begin failures++; $display("FAIL late_eng_done: valid=%b A=%h want 0/0", ifc.oOutValid, ifc.oA); end
    load_key(8'h10);
    expand(12);
  endtask

  task automatic test_counter_wrap;
    for (int k = 0; k < 5; k++)
      run_block($urandom, $urandom, 1'(k & 1), k + 1, 0, 2'((k + 1) % 4));
  endtask

  initial begin
    test_reset();
    test_key_and_block();
    test_backpressure();
    test_rekey();
    test_reset_mid();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rc5_session_ctrl.md
Name: rc5_session_ctrl

Overview:
Top-level sequencer for the RC5 core. It performs these steps in order:
- Loads a B-byte secret key into the key RAM.
- Kicks the key expander and waits for the S-table to be complete.
- Hands S-RAM port A to the cipher engine.
- Serves plaintext/ciphertext blocks over valid/ready handshakes, one block in flight at a time.

It sits between the host interface and the keyExpander/cipher/S_RAM/key_RAM instances and replaces ad-hoc flop-delayed start chaining.

Parameters:
W, 32, word width; block is 2*W bits (A,B)
B, 16, key length in bytes
B_LENGTH, $clog2(B), key RAM address width
CNT_W, 16, width of processed-block counter

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous reset, active-low
iKeyValid  input  1  key byte present on iKeyByte
iKeyByte  input  8  key byte, sent in address order 0..B-1
oKeyReady  output  1  controller accepts key bytes
oKey_we  output  1  key RAM write enable
oKey_addr  output  B_LENGTH  key RAM write address
oKey_data  output  8  key RAM write data
oExpStart  output  1  one-cycle start pulse to key expander
iExpDone  input  1  key expander done (level or pulse)
oS_sel  output  1  S-RAM port A owner: 0 expander, 1 cipher engine
iRekey  input  1  request new key; honoured only in IDLE
iInValid  input  1  input block valid
oInReady  output  1  controller accepts input block
iA, iB  input  W each  input block words
iDecrypt  input  1  mode for this block: 0 encrypt, 1 decrypt
oEngStart  output  1  one-cycle start pulse to cipher engine
oEngA, oEngB  output  W each  registered block words to engine
oEngDecrypt  output  1  registered mode to engine
iEngDone  input  1  engine done; result valid on iEngA/iEngB that cycle
iEngA, iEngB  input  W each  engine result
oOutValid  output  1  result block valid
iOutReady  input  1  consumer accepts result
oA, oB  output  W each  result words, held while oOutValid
oBlockCount  output  CNT_W  number of blocks delivered since last key load
oKeyLoaded  output  1  S-table valid for current key

Behaviour:
- Reset (rst==0 at posedge):
  - state=KEY_LOAD, key counter=0.
  - All outputs 0 except oKeyReady=1.
  - Overrides any state, including mid-expansion or mid-block. In-flight work is discarded.
  - Expander and engine are reset by the same rst.
- States: KEY_LOAD, EXP_START, EXP_WAIT, SETTLE, IDLE, RUN, OUT.
- KEY_LOAD:
  - oKeyReady=1.
  - oKey_we = iKeyValid (combinational), oKey_addr = counter, oKey_data = iKeyByte.
  - Counter increments per accepted byte.
  - On the byte with counter==B-1: counter wraps to 0 and next state is EXP_START.
- EXP_START: oExpStart=1 for exactly one cycle, oS_sel=0, then EXP_WAIT.
- EXP_WAIT:
  - Wait for iExpDone==1. The first high cycle is taken; later high cycles are ignored.
  - iExpDone already high on entry counts as done only if seen after EXP_START.
- SETTLE:
  - Exactly 2 cycles, which flushes the expander's last S-RAM write.
  - oS_sel goes 1 on entry.
  - Exit to IDLE with oKeyLoaded=1 and oBlockCount=0.
- IDLE:
  - oInReady=1.
  - A transfer occurs when iInValid && oInReady. On transfer, register iA/iB/iDecrypt into oEngA/oEngB/oEngDecrypt, pulse oEngStart on the next cycle, and go to RUN.
  - If iRekey and iInValid are both high in the same cycle, iRekey wins: go to KEY_LOAD, clear oKeyLoaded, set oS_sel=0, and do not accept the block.
- RUN:
  - oInReady=0.
  - On iEngDone, capture iEngA/iEngB into oA/oB and set oOutValid=1 the next cycle, entering OUT.
  - iRekey is ignored.
- OUT:
  - oOutValid=1, oA/oB held stable until iOutReady.
  - On iOutReady: oOutValid drops next cycle, oBlockCount+1 (wraps at 2^CNT_W-1 -> 0), return to IDLE.
  - The next input block can be accepted the cycle after return to IDLE; no overlap of blocks.
- Latency: input handshake -> oEngStart = 1 cycle; iEngDone -> oOutValid = 1 cycle.
- iKeyValid outside KEY_LOAD is ignored and oKey_we stays 0. iEngDone outside RUN is ignored.
- oS_sel is registered and changes only on the state transitions above.

Test Plan:
- Reset, key load: release rst, send bytes 0x00..0x0F with iKeyValid continuous -> oKey_we high 16 cycles, oKey_addr 0..15, oExpStart single pulse the cycle after byte 15.
- Expand then block: iExpDone pulses after 100 cycles -> oS_sel=1 two cycles before oInReady=1 and oKeyLoaded=1. Send iA=0, iB=0, encrypt with an engine model -> oEngStart 1 cycle after handshake; oA/oB equal engine output 1 cycle after iEngDone; oBlockCount=1.
- Backpressure: hold iOutReady=0 for 10 cycles in OUT -> oA/oB stable, oInReady=0 throughout; release -> oOutValid drops, oInReady=1 next cycle.
- Rekey collision: in IDLE, drive iRekey=1 and iInValid=1 together -> block not accepted, state KEY_LOAD, oKeyLoaded=0, oS_sel=0, oBlockCount reset to 0 after the next SETTLE.
- Reset mid-operation: assert rst=0 during EXP_WAIT and again during RUN -> next cycle all outputs 0, oKeyReady=1, key counter 0. A late iEngDone or iExpDone is ignored.
- Counter wrap: with CNT_W=2, run 5 blocks -> oBlockCount sequence 1,2,3,0,1.
